// File: rtl/hook_overlay_pkg.sv
// hook_overlay_pkg
// Shared definitions for the hook overlay block.
//   RGB_W           width of an RGB444 pixel
//   HOOK_W, HOOK_H  hook sprite bounding box (columns, rows)
//   HOOK_DY_MIN/MAX per-column range of rows drawn, relative to the hook origin
//   state_t         position-update FSM states
//   hook_mask()     tests one sprite-relative coordinate against the mask
package hook_overlay_pkg;

  localparam int RGB_W     = 12;
  localparam int HOOK_W    = 7;
  localparam int HOOK_H    = 10;
  localparam int HOOK_DY_W = 4;

  // Column dx of the sprite covers rows HOOK_DY_MIN[dx]..HOOK_DY_MAX[dx].
  localparam logic [HOOK_DY_W-1:0] HOOK_DY_MIN [HOOK_W] =
    '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
  localparam logic [HOOK_DY_W-1:0] HOOK_DY_MAX [HOOK_W] =
    '{4'd9, 4'd8, 4'd8, 4'd7, 4'd7, 4'd6, 4'd6};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DIV    = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Caller guarantees dx < 8 and dy < 16; the column range is checked here.
  function automatic logic hook_mask(input logic [2:0] dx,
                                     input logic [HOOK_DY_W-1:0] dy);
    if (dx >= 3'(HOOK_W)) return 1'b0;
    return (dy >= HOOK_DY_MIN[dx]) && (dy <= HOOK_DY_MAX[dx]);
  endfunction

endpackage

// File: rtl/hook_div.sv
// hook_div
// Serial restoring divider by a constant DIVISOR, one quotient bit per clock.
// A quotient takes exactly WIDTH cycles: the cycle with start high computes
// the MSB, and done is high on the cycle computing the LSB, with the complete
// quotient presented combinationally on that same cycle. A new start may be
// issued on the cycle after done, giving back-to-back quotients with no gap.
// start overrides any division in progress. The remainder is discarded.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      begin a division of dividend (sampled this cycle)
//   dividend   value to divide
//   quotient   result, valid while done is high
//   done       last quotient bit is being computed this cycle
module hook_div #(
  parameter int WIDTH   = 14,
  parameter int DIVISOR = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  output logic [WIDTH-1:0] quotient,
  output logic             done
);

  localparam int              CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0]  DIV_V = (WIDTH + 1)'(DIVISOR);

  logic [WIDTH-1:0] rem_q, work_q, quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [WIDTH-1:0] rem_in, work_in, quo_in;
  logic [CNT_W-1:0] cnt_in;
  logic [WIDTH:0]   shifted;
  logic             active, ge;
  logic [WIDTH-1:0] rem_d, work_d, quo_d;

  always_comb begin
    // A start cycle works on the fresh operand instead of the registers.
    rem_in  = start ? '0       : rem_q;
    work_in = start ? dividend : work_q;
    quo_in  = start ? '0       : quo_q;
    cnt_in  = start ? '0       : cnt_q;
    active  = start | run_q;

    shifted = {rem_in, work_in[WIDTH-1]};
    ge      = (shifted >= DIV_V);
    rem_d   = ge ? WIDTH'(shifted - DIV_V) : WIDTH'(shifted);
    quo_d   = WIDTH'({quo_in, ge});
    work_d  = work_in << 1;

    done     = active && (cnt_in == CNT_W'(WIDTH - 1));
    quotient = quo_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      work_q <= '0;
      quo_q  <= '0;
    end else if (active) begin
      rem_q  <= rem_d;
      work_q <= work_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_in + CNT_W'(1);
      run_q  <= !done;
    end
  end

endmodule

// File: rtl/hook_overlay.sv
// hook_overlay
// Composites up to CHANNELS fishing lines and hook sprites over a background
// RGB444 pixel stream, one pixel per clock, with one cycle of latency.
// Raw positions are divided by SCALE once per frame by a single shared serial
// divider; all results are swapped into shadow registers in one cycle so the
// drawn image only ever changes between two pixels, never mid-divide.
// Handshake: frame_start is a one-cycle request with no acknowledge; busy is
// high from the cycle after a request until the new shadow values are in use.
// A request while busy restarts the snapshot and discards partial quotients.
// Ports:
//   clk, rst      pixel clock, synchronous active-high reset
//   frame_start   pulse at start of vertical blank; triggers a position update
//   h_position    raw hook x per channel, packed, ch0 in LSBs
//   v_position    raw hook y per channel, packed
//   line_x        line column per channel, packed
//   ch_enable     per-channel draw enable, sampled with positions
//   valid         active-video flag
//   h_cnt, v_cnt  current pixel column/row
//   pixel         background RGB444
//   vga           composited RGB444, registered
//   busy          position update in progress
module hook_overlay
  import hook_overlay_pkg::*;
#(
  parameter int                      CHANNELS = 2,
  parameter int                      POS_W    = 14,
  parameter int                      CNT_W    = 10,
  parameter int                      SCALE    = 10,
  parameter int                      LINE_TOP = 72,
  parameter logic [CHANNELS*12-1:0]  CH_COLOR = {CHANNELS{12'hfff}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [CHANNELS*POS_W-1:0] h_position,
  input  logic [CHANNELS*POS_W-1:0] v_position,
  input  logic [CHANNELS*CNT_W-1:0] line_x,
  input  logic [CHANNELS-1:0]       ch_enable,
  input  logic                      valid,
  input  logic [CNT_W-1:0]          h_cnt,
  input  logic [CNT_W-1:0]          v_cnt,
  input  logic [RGB_W-1:0]          pixel,
  output logic [RGB_W-1:0]          vga,
  output logic                      busy
);

  // Quotients are ordered ch0 x, ch0 y, ch1 x, ch1 y, ...
  localparam int NQ   = 2 * CHANNELS;
  localparam int QI_W = (NQ > 1) ? $clog2(NQ) : 1;
  // Pixel comparisons use the wider of the position and counter widths so an
  // out-of-range quotient can never alias onto a visible pixel.
  localparam int CW   = (POS_W > CNT_W) ? POS_W : CNT_W;

  state_t state_q, state_d;

  logic [POS_W-1:0]    stage_val [NQ];
  logic [CNT_W-1:0]    stage_lx  [CHANNELS];
  logic [CHANNELS-1:0] stage_en;
  logic [POS_W-1:0]    quo_q     [NQ];
  logic [QI_W-1:0]     q_idx;
  logic                launch;

  logic [POS_W-1:0]    shadow_h  [CHANNELS];
  logic [POS_W-1:0]    shadow_v  [CHANNELS];
  logic [CNT_W-1:0]    shadow_lx [CHANNELS];
  logic [CHANNELS-1:0] shadow_en;

  logic [RGB_W-1:0]    vga_q, pix_d;
  logic [CHANNELS-1:0] hit;

  logic                div_start, div_done;
  logic [POS_W-1:0]    div_quo;

  // ---------------------------------------------------------------------
  // Update FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (frame_start) state_d = ST_LOAD;
      ST_LOAD:   state_d = ST_DIV;
      ST_DIV:    if (div_done && (q_idx == QI_W'(NQ - 1))) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // A new frame always restarts the update from a fresh snapshot.
    if (frame_start) state_d = ST_LOAD;
  end

  assign busy      = (state_q != ST_IDLE);
  // launch is high on the first cycle of each quotient.
  assign div_start = (state_q == ST_DIV) && launch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      launch    <= 1'b0;
      q_idx     <= '0;
      shadow_en <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        shadow_h[k]  <= '0;
        shadow_v[k]  <= '0;
        shadow_lx[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_LOAD: begin
          launch <= 1'b1;
          q_idx  <= '0;
        end
        ST_DIV: begin
          launch <= div_done;
          if (div_done && (q_idx != QI_W'(NQ - 1))) q_idx <= q_idx + QI_W'(1);
        end
        ST_COMMIT: begin
          shadow_en <= stage_en;
          for (int k = 0; k < CHANNELS; k++) begin
            shadow_h[k]  <= quo_q[2*k];
            shadow_v[k]  <= quo_q[2*k+1];
            shadow_lx[k] <= stage_lx[k];
          end
        end
        default: ;
      endcase
    end
  end

  // Staging and quotient registers are only read after being written in
  // the same update, so they need no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) begin
      stage_en <= ch_enable;
      for (int k = 0; k < CHANNELS; k++) begin
        stage_val[2*k]   <= h_position[k*POS_W +: POS_W];
        stage_val[2*k+1] <= v_position[k*POS_W +: POS_W];
        stage_lx[k]      <= line_x[k*CNT_W +: CNT_W];
      end
    end
    if ((state_q == ST_DIV) && div_done) quo_q[q_idx] <= div_quo;
  end

  hook_div #(
    .WIDTH   (POS_W),
    .DIVISOR (SCALE)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (stage_val[q_idx]),
    .quotient (div_quo),
    .done     (div_done)
  );

  // ---------------------------------------------------------------------
  // Per-channel hit detection
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < CHANNELS; k++) begin : g_hit
    logic [CW-1:0] hc, vc, hx, hy, dx, dy;
    logic          line_hit, in_box, hook_hit;

    assign hc = CW'(h_cnt);
    assign vc = CW'(v_cnt);
    assign hx = CW'(shadow_h[k]);
    assign hy = CW'(shadow_v[k]);
    assign dx = hc - hx;
    assign dy = vc - hy;

    assign line_hit = (h_cnt == shadow_lx[k]) &&
                      (vc >= CW'(LINE_TOP)) && (vc <= hy);
    // Differences are only meaningful once both are known non-negative.
    assign in_box   = (hc >= hx) && (vc >= hy) &&
                      (dx < CW'(HOOK_W)) && (dy < CW'(HOOK_H));
    assign hook_hit = in_box && hook_mask(dx[2:0], dy[HOOK_DY_W-1:0]);

    assign hit[k] = shadow_en[k] && (line_hit || hook_hit);
  end

  // ---------------------------------------------------------------------
  // Priority composite and output register
  // ---------------------------------------------------------------------
  always_comb begin
    pix_d = pixel;
    // Walk from the highest index down so the lowest hitting channel wins.
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (hit[k]) pix_d = CH_COLOR[k*RGB_W +: RGB_W];
    end
    if (!valid) pix_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) vga_q <= '0;
    else     vga_q <= pix_d;
  end

  assign vga = vga_q;

endmodule

// File: tb/tb_hook_overlay.sv
// tb_hook_overlay
// Directed test of hook_overlay with two channels: ch0 colour 12'hf00,
// ch1 colour 12'h0f0, background 12'h123. Expected values are computed by
// hand from the raw positions divided by 10.
module tb_hook_overlay;

  localparam int CHANNELS = 2;
  localparam int POS_W    = 14;
  localparam int CNT_W    = 10;
  localparam logic [CHANNELS*12-1:0] COLORS = {12'h0f0, 12'hf00};
  localparam logic [11:0] C0 = 12'hf00;
  localparam logic [11:0] C1 = 12'h0f0;
  localparam logic [11:0] BG = 12'h123;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic                      frame_start;
  logic [CHANNELS*POS_W-1:0] h_position;
  logic [CHANNELS*POS_W-1:0] v_position;
  logic [CHANNELS*CNT_W-1:0] line_x;
  logic [CHANNELS-1:0]       ch_enable;
  logic                      valid;
  logic [CNT_W-1:0]          h_cnt;
  logic [CNT_W-1:0]          v_cnt;
  logic [11:0]               pixel;
  logic [11:0]               vga;
  logic                      busy;

  int checks = 0;
  int errors = 0;
  int n;

  hook_overlay #(
    .CHANNELS (CHANNELS),
    .POS_W    (POS_W),
    .CNT_W    (CNT_W),
    .SCALE    (10),
    .LINE_TOP (72),
    .CH_COLOR (COLORS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .h_position  (h_position),
    .v_position  (v_position),
    .line_x      (line_x),
    .ch_enable   (ch_enable),
    .valid       (valid),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .pixel       (pixel),
    .vga         (vga),
    .busy        (busy)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input int h, input int v, input int lx);
    h_position[k*POS_W +: POS_W] = POS_W'(h);
    v_position[k*POS_W +: POS_W] = POS_W'(v);
    line_x[k*CNT_W +: CNT_W]     = CNT_W'(lx);
  endtask

  // Present one pixel, clock it, then compare the registered output.
  task automatic pix(input string tag, input int h, input int v, input logic vld,
                     input logic [11:0] exp);
    valid = vld;
    h_cnt = CNT_W'(h);
    v_cnt = CNT_W'(v);
    pixel = BG;
    step();
    chk(tag, {20'd0, vga}, {20'd0, exp});
  endtask

  // Returns in cycle 1 relative to the pulse (the LOAD cycle).
  task automatic pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Counts cycles until busy falls, starting from cycle number start_n.
  task automatic wait_idle(input int start_n, output int cnt);
    cnt = start_n;
    while (busy && cnt < 300) begin
      step();
      cnt++;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; frame_start = 1'b0; h_position = '0; v_position = '0;
    line_x = '0; ch_enable = '0; valid = 1'b1; h_cnt = '0; v_cnt = '0;
    pixel = BG;
    step(); step();
    chk("reset_vga", {20'd0, vga}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;

    // Nothing committed yet: background passes through.
    pix("pass_hookpos", 300, 150, 1'b1, BG);
    pix("pass_origin", 0, 0, 1'b1, BG);
    pix("pass_linepos", 258, 100, 1'b1, BG);
    chk("idle_busy", {31'd0, busy}, 32'h0);

    // Single channel: hook at (300,150), line at column 258.
    set_ch(0, 3000, 1500, 258);
    set_ch(1, 0, 0, 1000);
    ch_enable = 2'b01;
    pulse();
    chk("busy_rise", {31'd0, busy}, 32'h1);
    wait_idle(1, n);
    chk("update_latency", 32'(n), 32'd59);
    pix("hook_top", 300, 150, 1'b1, C0);
    pix("hook_stem_end", 300, 159, 1'b1, C0);
    pix("hook_tip", 306, 156, 1'b1, C0);
    pix("line_top", 258, 72, 1'b1, C0);
    pix("line_bottom", 258, 150, 1'b1, C0);
    pix("right_of_hook", 307, 156, 1'b1, BG);
    pix("above_line", 258, 71, 1'b1, BG);
    pix("below_line", 258, 151, 1'b1, BG);
    pix("below_stem", 300, 160, 1'b1, BG);
    pix("blank_over_hook", 300, 150, 1'b0, 12'h000);

    // Two overlapping hooks: ch1 at (302,153), line at 400.
    set_ch(1, 3020, 1530, 400);
    ch_enable = 2'b11;
    pulse();
    wait_idle(1, n);
    chk("latency_two_ch", 32'(n), 32'd59);
    pix("overlap_ch0_wins", 302, 155, 1'b1, C0);
    pix("ch1_only_hook", 302, 160, 1'b1, C1);
    pix("ch1_line", 400, 100, 1'b1, C1);

    ch_enable = 2'b10;
    pulse();
    wait_idle(1, n);
    pix("overlap_ch0_off", 302, 155, 1'b1, C1);
    pix("ch0_off_bg", 300, 150, 1'b1, BG);

    // Restart: pulse with B, then mid-divide pulse with C, then change to D
    // after the LOAD sample. Only C may appear.
    ch_enable = 2'b11;
    set_ch(0, 1000, 500, 258);
    pulse();
    pix("old_image_held_a", 302, 155, 1'b1, C1);
    pix("old_image_held_b", 300, 150, 1'b1, BG);
    chk("busy_mid_div", {31'd0, busy}, 32'h1);
    for (int i = 0; i < 15; i++) step();
    set_ch(0, 5127, 831, 600);
    pulse();
    step();
    set_ch(0, 2000, 2000, 700);
    wait_idle(2, n);
    chk("restart_latency", 32'(n), 32'd59);
    pix("c_hook_origin", 512, 83, 1'b1, C0);
    pix("c_hook_diag", 513, 84, 1'b1, C0);
    pix("c_above_hook", 512, 82, 1'b1, BG);
    pix("c_line_top", 600, 72, 1'b1, C0);
    pix("c_line_end", 600, 83, 1'b1, C0);
    pix("c_line_past", 600, 84, 1'b1, BG);
    pix("b_not_drawn", 100, 50, 1'b1, BG);
    pix("d_not_drawn", 200, 200, 1'b1, BG);
    pix("old_line_gone", 258, 100, 1'b1, BG);
    pix("ch1_redivided", 302, 155, 1'b1, C1);

    // Hook at row 0: bottom row of the screen must not wrap onto it.
    set_ch(0, 3000, 0, 258);
    pulse();
    wait_idle(1, n);
    pix("no_wrap", 300, 1023, 1'b1, BG);
    pix("row0_hook", 300, 0, 1'b1, C0);
    pix("row0_tip", 306, 6, 1'b1, C0);

    // Reset in the middle of a divide.
    pulse();
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    valid = 1'b1; h_cnt = 10'd300; v_cnt = 10'd0;
    step();
    chk("rst_mid_busy", {31'd0, busy}, 32'h0);
    chk("rst_mid_vga", {20'd0, vga}, 32'h0);
    rst = 1'b0;
    pix("post_rst_ch0", 300, 0, 1'b1, BG);
    pix("post_rst_ch1", 302, 155, 1'b1, BG);
    chk("post_rst_idle", {31'd0, busy}, 32'h0);
    pulse();
    wait_idle(1, n);
    chk("post_rst_latency", 32'(n), 32'd59);
    pix("post_rst_redraw", 300, 0, 1'b1, C0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
